// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache that refills whole lines over a req/ack memory port.
// Defining ICACHE_STATS_EN adds free-running hit/miss counters (hit_cnt_o, miss_cnt_o).
module icache_dm #(
    parameter int          LINE_WORDS = 4,
    parameter int          LINES      = 16,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_inst_o,
    output logic        cpu_stall_o,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);
    localparam int OFFSET_W = $clog2(LINE_WORDS);
    localparam int INDEX_W  = $clog2(LINES);
    localparam int TAG_W    = 32 - OFFSET_W - INDEX_W - 2;
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(LINE_WORDS - 1);

    typedef enum logic {IDLE, REFILL} state_t;
    state_t state, state_nxt;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [31:0]      data_arr [LINES*LINE_WORDS];

    logic [OFFSET_W-1:0] offset;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic [TAG_W-1:0]    rf_tag;
    logic [INDEX_W-1:0]  rf_index;
    logic [OFFSET_W-1:0] fill_cnt;
    logic                pend_flush;
    logic                hit;
    logic                miss;
    logic                fill_ack;
    logic                fill_done;
    logic                unused_addr_bits;

    assign offset           = cpu_addr_i[OFFSET_W+1:2];
    assign index            = cpu_addr_i[OFFSET_W+INDEX_W+1:OFFSET_W+2];
    assign tag              = cpu_addr_i[31:OFFSET_W+INDEX_W+2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign hit  = (state == IDLE) && cpu_req_i && valid[index] && (tag_arr[index] == tag);
    assign miss = (state == IDLE) && cpu_req_i && !hit;

    // The refill pointer registers double as the memory address, so it cannot move during wait states.
    assign mem_addr_o = {rf_tag, rf_index, fill_cnt, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cpu_inst_o  = NOP_INST;
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        fill_ack    = 1'b0;
        fill_done   = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    cpu_inst_o = data_arr[{index, offset}];
                end else if (miss) begin
                    cpu_stall_o = 1'b1;
                    state_nxt   = REFILL;
                end
            end
            REFILL: begin
                mem_req_o   = 1'b1;
                cpu_stall_o = 1'b1;
                fill_ack    = mem_ack_i;
                if (mem_ack_i && (fill_cnt == LAST_WORD)) begin
                    fill_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A flush seen during refill is deferred so the completing line is invalidated along with the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= '0;
            rf_tag     <= '0;
            rf_index   <= '0;
            fill_cnt   <= '0;
            pend_flush <= 1'b0;
        end else begin
            if (miss) begin
                rf_tag       <= tag;
                rf_index     <= index;
                fill_cnt     <= '0;
                valid[index] <= 1'b0;
            end
            if ((state == IDLE) && flush_i) begin
                valid <= '0;
            end
            if (fill_ack) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if ((state == REFILL) && flush_i) begin
                pend_flush <= 1'b1;
            end
            if (fill_done) begin
                if (pend_flush || flush_i) begin
                    valid <= '0;
                end else begin
                    valid[rf_index] <= 1'b1;
                end
                pend_flush <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (miss) begin
            tag_arr[index] <= tag;
        end
        if (fill_ack) begin
            data_arr[{rf_index, fill_cnt}] <= mem_data_i;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (miss) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: randomized self-checking bench for icache_dm against a line-level cache model
// and a hashed backing memory with configurable wait states.
module tb_icache_dm;
    localparam int          LW  = 4;
    localparam int          NL  = 16;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        cpu_req_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_inst_o;
    logic        cpu_stall_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    icache_dm #(.LINE_WORDS(LW), .LINES(NL), .NOP_INST(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req_i  (cpu_req_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_inst_o (cpu_inst_o),
        .cpu_stall_o(cpu_stall_o),
        .flush_i    (flush_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory contents are a hash of the word address.
    logic [31:0] salt;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        return (w * 32'h9E37_79B1) ^ salt;
    endfunction

    // Memory responder: acks after mem_wait idle request cycles, logs every acked address.
    int          mem_wait = 0;
    int          wait_cnt = 0;
    logic        addr_moved = 1'b0;
    logic        last_pending = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] ack_log[$];

    always @(negedge clk) begin
        mem_data_i = $urandom;
        if (rst || !mem_req_o) begin
            mem_ack_i    = 1'b0;
            wait_cnt     = 0;
            last_pending = 1'b0;
        end else begin
            if (last_pending && (mem_addr_o !== last_addr)) addr_moved = 1'b1;
            if (wait_cnt >= mem_wait) begin
                mem_ack_i    = 1'b1;
                mem_data_i   = mem_word(mem_addr_o);
                ack_log.push_back(mem_addr_o);
                wait_cnt     = 0;
                last_pending = 1'b0;
            end else begin
                mem_ack_i    = 1'b0;
                wait_cnt     = wait_cnt + 1;
                last_pending = 1'b1;
                last_addr    = mem_addr_o;
            end
        end
    end

    // Reference model: which memory block each line currently holds.
    bit          ref_valid [NL];
    logic [31:0] ref_blk   [NL];

    function automatic int line_of(input logic [31:0] a);
        return int'((a / (4 * LW)) % NL);
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[line_of(a)] && (ref_blk[line_of(a)] == a / (4 * LW));
    endfunction

    function automatic void ref_flush();
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
    endfunction

    function automatic void ref_after(input logic [31:0] a, input bit flush, input bit was_hit);
        if (flush) ref_flush();
        if (!was_hit) begin
            ref_valid[line_of(a)] = 1'b1;
            ref_blk[line_of(a)]   = a / (4 * LW);
        end
    endfunction

    function automatic int exp_stalls(input logic [31:0] a, input int w);
        return ref_hit(a) ? 0 : 1 + LW * (w + 1);
    endfunction

    // Issue one fetch and hold it until the stall drops (bounded); flush_i is held for the first edge only.
    task automatic fetch(input logic [31:0] a, input bit flush, output int stalls, output logic [31:0] inst);
        @(negedge clk);
        cpu_req_i  = 1'b1;
        cpu_addr_i = a;
        flush_i    = flush;
        #1;
        stalls = 0;
        while ((cpu_stall_o === 1'b1) && (stalls < 200)) begin
            @(negedge clk);
            flush_i = 1'b0;
            #1;
            stalls++;
        end
        inst = cpu_inst_o;
        if (flush_i) begin
            @(posedge clk);
            #1;
            flush_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        cpu_req_i  = 1'b0;
        cpu_addr_i = '0;
        flush_i    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_flush();
        #1;
        checks++;
        if (cpu_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", cpu_stall_o); end
        checks++;
        if (cpu_inst_o !== NOP) begin failures++; $display("[TB] FAIL reset_inst got=%h exp=%h", cpu_inst_o, NOP); end
        checks++;
        if (mem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req got=%b exp=0", mem_req_o); end
        checks++;
        if (mem_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr_o); end
    endtask

    task automatic test_cold_miss();
        int          st;
        logic [31:0] inst;
        int          exp;
        bit          h;
        mem_wait = 0;
        ack_log.delete();
        h   = ref_hit(32'h10);
        exp = exp_stalls(32'h10, 0);
        fetch(32'h10, 1'b0, st, inst);
        ref_after(32'h10, 1'b0, h);
        checks++;
        if (st !== 5) begin failures++; $display("[TB] FAIL cold_stall_cycles got=%0d exp=5 model=%0d", st, exp); end
        checks++;
        if (ack_log.size() !== LW) begin failures++; $display("[TB] FAIL cold_ack_count got=%0d exp=%0d", ack_log.size(), LW); end
        for (int i = 0; i < LW; i++) begin
            logic [31:0] ea;
            logic [31:0] ga;
            ea = 32'h10 + 32'(4 * i);
            ga = (i < ack_log.size()) ? ack_log[i] : 32'hDEAD_BEEF;
            checks++;
            if (ga !== ea) begin failures++; $display("[TB] FAIL cold_mem_addr[%0d] got=%h exp=%h", i, ga, ea); end
        end
        checks++;
        if (inst !== mem_word(32'h10)) begin failures++; $display("[TB] FAIL cold_inst got=%h exp=%h", inst, mem_word(32'h10)); end

        h   = ref_hit(32'h1C);
        exp = exp_stalls(32'h1C, 0);
        fetch(32'h1C, 1'b0, st, inst);
        ref_after(32'h1C, 1'b0, h);
        checks++;
        if (st !== exp) begin failures++; $display("[TB] FAIL hit_stall got=%0d exp=%0d", st, exp); end
        checks++;
        if (inst !== mem_word(32'h1C)) begin failures++; $display("[TB] FAIL hit_inst got=%h exp=%h", inst, mem_word(32'h1C)); end
`ifdef ICACHE_STATS_EN
        checks++;
        if (miss_cnt_o !== 32'd1) begin failures++; $display("[TB] FAIL stats_miss got=%0d exp=1", miss_cnt_o); end
        checks++;
        if (hit_cnt_o !== 32'd1) begin failures++; $display("[TB] FAIL stats_hit got=%0d exp=1", hit_cnt_o); end
`endif
    endtask

    task automatic test_conflict();
        logic [31:0] seq [2];
        int          st;
        logic [31:0] inst;
        int          exp;
        bit          h;
        seq[0]   = 32'h110;
        seq[1]   = 32'h10;
        mem_wait = 0;
        for (int i = 0; i < 2; i++) begin
            h   = ref_hit(seq[i]);
            exp = exp_stalls(seq[i], 0);
            fetch(seq[i], 1'b0, st, inst);
            ref_after(seq[i], 1'b0, h);
            checks++;
            if (st !== exp) begin failures++; $display("[TB] FAIL conflict_stall[%0d] got=%0d exp=%0d", i, st, exp); end
            checks++;
            if (inst !== mem_word(seq[i])) begin failures++; $display("[TB] FAIL conflict_inst[%0d] got=%h exp=%h", i, inst, mem_word(seq[i])); end
        end
    endtask

    task automatic test_wait_states();
        int          st;
        logic [31:0] inst;
        int          exp;
        bit          h;
        mem_wait   = 2;
        addr_moved = 1'b0;
        ack_log.delete();
        h   = ref_hit(32'h24);
        exp = exp_stalls(32'h24, 2);
        fetch(32'h24, 1'b0, st, inst);
        ref_after(32'h24, 1'b0, h);
        checks++;
        if (st !== 13) begin failures++; $display("[TB] FAIL wait_stall_cycles got=%0d exp=13 model=%0d", st, exp); end
        checks++;
        if (addr_moved !== 1'b0) begin failures++; $display("[TB] FAIL wait_addr_stable got=%b exp=0", addr_moved); end
        checks++;
        if (ack_log.size() !== LW) begin failures++; $display("[TB] FAIL wait_ack_count got=%0d exp=%0d", ack_log.size(), LW); end
        checks++;
        if (inst !== mem_word(32'h24)) begin failures++; $display("[TB] FAIL wait_inst got=%h exp=%h", inst, mem_word(32'h24)); end
    endtask

    task automatic test_flush_refill();
        int          n;
        int          st;
        logic [31:0] inst;
        int          exp;
        bit          h;
        mem_wait = 1;
        ack_log.delete();
        @(negedge clk);
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h40;
        #1;
        checks++;
        if (cpu_stall_o !== 1'b1) begin failures++; $display("[TB] FAIL flushr_miss_stall got=%b exp=1", cpu_stall_o); end
        @(negedge clk);
        cpu_req_i  = 1'b0;
        cpu_addr_i = $urandom;
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        n = 0;
        while ((cpu_stall_o === 1'b1) && (n < 100)) begin
            @(negedge clk);
            #1;
            n++;
        end
        ref_flush();
        checks++;
        if (ack_log.size() !== LW) begin failures++; $display("[TB] FAIL flushr_ack_count got=%0d exp=%0d", ack_log.size(), LW); end
        checks++;
        if ((ack_log.size() < 1) || (ack_log[0] !== 32'h40)) begin failures++; $display("[TB] FAIL flushr_first_addr exp=40"); end
        checks++;
        if ((ack_log.size() < LW) || (ack_log[LW-1] !== 32'h4C)) begin failures++; $display("[TB] FAIL flushr_last_addr exp=4c"); end
        h   = ref_hit(32'h40);
        exp = exp_stalls(32'h40, 1);
        fetch(32'h40, 1'b0, st, inst);
        ref_after(32'h40, 1'b0, h);
        checks++;
        if (st !== exp) begin failures++; $display("[TB] FAIL flushr_refetch_stall got=%0d exp=%0d", st, exp); end
        checks++;
        if (inst !== mem_word(32'h40)) begin failures++; $display("[TB] FAIL flushr_refetch_inst got=%h exp=%h", inst, mem_word(32'h40)); end
    endtask

    task automatic test_flush_idle();
        logic [31:0] seq [3];
        bit          fl  [3];
        int          st;
        logic [31:0] inst;
        int          exp;
        bit          h;
        seq[0] = 32'h44;  fl[0] = 1'b1;
        seq[1] = 32'h10;  fl[1] = 1'b0;
        seq[2] = 32'h48;  fl[2] = 1'b0;
        mem_wait = 0;
        for (int i = 0; i < 3; i++) begin
            h   = ref_hit(seq[i]);
            exp = exp_stalls(seq[i], 0);
            fetch(seq[i], fl[i], st, inst);
            ref_after(seq[i], fl[i], h);
            checks++;
            if (st !== exp) begin failures++; $display("[TB] FAIL flushi_stall[%0d] got=%0d exp=%0d", i, st, exp); end
            checks++;
            if (inst !== mem_word(seq[i])) begin failures++; $display("[TB] FAIL flushi_inst[%0d] got=%h exp=%h", i, inst, mem_word(seq[i])); end
        end
    endtask

    task automatic test_reset_refill();
        int          n;
        int          st;
        logic [31:0] inst;
        mem_wait = 0;
        ack_log.delete();
        @(negedge clk);
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h80;
        n = 0;
        while ((ack_log.size() < 2) && (n < 20)) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (mem_addr_o !== 32'h88) begin failures++; $display("[TB] FAIL rstr_word2_addr got=%h exp=88", mem_addr_o); end
        cpu_req_i = 1'b0;
        rst       = 1'b1;
        #1;
        checks++;
        if (mem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL rstr_async_req got=%b exp=0", mem_req_o); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_flush();
        ack_log.delete();
        fetch(32'h80, 1'b0, st, inst);
        ref_after(32'h80, 1'b0, 1'b0);
        checks++;
        if (st !== 5) begin failures++; $display("[TB] FAIL rstr_refill_stall got=%0d exp=5", st); end
        checks++;
        if ((ack_log.size() < 1) || (ack_log[0] !== 32'h80)) begin failures++; $display("[TB] FAIL rstr_first_addr exp=80"); end
        checks++;
        if (inst !== mem_word(32'h80)) begin failures++; $display("[TB] FAIL rstr_inst got=%h exp=%h", inst, mem_word(32'h80)); end
    endtask

    task automatic test_random();
        int          st;
        logic [31:0] inst;
        logic [31:0] a;
        int          exp;
        bit          h;
        bit          fl;
        for (int it = 0; it < 40; it++) begin
            a = ($urandom_range(3, 0) << 8) | ($urandom_range(NL - 1, 0) << 4)
              | ($urandom_range(LW - 1, 0) << 2) | $urandom_range(3, 0);
            fl       = ($urandom_range(7, 0) == 0);
            mem_wait = $urandom_range(2, 0);
            h        = ref_hit(a);
            exp      = exp_stalls(a, mem_wait);
            fetch(a, fl, st, inst);
            ref_after(a, fl, h);
            checks++;
            if (st !== exp) begin failures++; $display("[TB] FAIL rand_stall[%0d] addr=%h got=%0d exp=%0d", it, a, st, exp); end
            checks++;
            if (inst !== mem_word(a)) begin failures++; $display("[TB] FAIL rand_inst[%0d] addr=%h got=%h exp=%h", it, a, inst, mem_word(a)); end
            if ($urandom_range(3, 0) == 0) begin
                @(negedge clk);
                cpu_req_i  = 1'b0;
                cpu_addr_i = $urandom;
                #1;
                checks++;
                if (cpu_stall_o !== 1'b0) begin failures++; $display("[TB] FAIL rand_idle_stall[%0d] got=%b exp=0", it, cpu_stall_o); end
                checks++;
                if (cpu_inst_o !== NOP) begin failures++; $display("[TB] FAIL rand_idle_inst[%0d] got=%h exp=%h", it, cpu_inst_o, NOP); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        salt       = $urandom;
        rst        = 1'b1;
        cpu_req_i  = 1'b0;
        cpu_addr_i = '0;
        flush_i    = 1'b0;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_wait_states();
        test_flush_refill();
        test_flush_idle();
        test_reset_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
